// File: rtl/ctz_seq_unit.sv
// Sequential count-trailing-zeros, SCAN_W bits/cycle; result NCHUNK+1 cycles after accept, held until out_ready.
// CTZ_EARLY_EXIT_EN: leave SCAN as soon as the first set bit is found (same results, shorter latency).
module ctz_seq_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH):0]   out_count,
  output logic                          out_zero,
  output logic                          busy
);

  localparam int NCHUNK = DATA_WIDTH / SCAN_W;
  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic                  found;
  logic [IDX_W-1:0]      idx;

  logic [SCAN_W-1:0]     chunk;
  logic [CNT_W-1:0]      low_pos;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  found_nxt;
  logic                  last_chunk;
  logic                  scan_exit;

  assign in_ready   = (state == IDLE) && !rst;
  assign chunk      = shreg[SCAN_W-1:0];
  assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

  // Descending walk so the lowest set bit wins.
  always_comb begin
    low_pos = '0;
    for (int i = SCAN_W - 1; i >= 0; i--) begin
      if (chunk[i]) low_pos = CNT_W'(i);
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    found_nxt = found;
    if (!found) begin
      if (chunk != '0) begin
        cnt_nxt   = cnt + low_pos;
        found_nxt = 1'b1;
      end else begin
        cnt_nxt   = cnt + CNT_W'(SCAN_W);
      end
    end
  end

`ifdef CTZ_EARLY_EXIT_EN
  assign scan_exit = last_chunk || found_nxt;
`else
  assign scan_exit = last_chunk;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      found     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg <= in_data;
            cnt   <= '0;
            found <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          shreg <= shreg >> SCAN_W;
          idx   <= idx + 1'b1;
          cnt   <= cnt_nxt;
          found <= found_nxt;
          if (scan_exit) begin
            out_valid <= 1'b1;
            out_count <= cnt_nxt;
            out_zero  <= !found_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
